// File: rtl/imul_pkg.sv
// ============================================================================
// imul_pkg : shared types and request-bundle bit positions for imul blocks
// Rev 1.0
// ============================================================================
`default_nettype none

package imul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    // Mode bits sit above the two operands in req_msg.
    function automatic int sgn_pos(input int nbits);
        return 2 * nbits + 1;
    endfunction

    function automatic int hi_pos(input int nbits);
        return 2 * nbits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/imul_zero_skip.sv
// ============================================================================
// imul_zero_skip : shift amount (1 + run of zeros above bit 0, capped) and
//                  last-step flag for the iterative multiplier
// Rev 1.0
// ============================================================================
`default_nettype none

module imul_zero_skip #(
    parameter int NBITS    = 32,
    parameter int MAX_SKIP = 4,
    localparam int SW      = $clog2(MAX_SKIP + 1)
) (
    input  logic [NBITS-1:0] b_reg,
    output logic [SW-1:0]    s,
    output logic             last
);

    logic run;

    always_comb begin
        s   = SW'(1);
        run = 1'b1;
        for (int k = 1; k < MAX_SKIP; k++) begin
            if (run && !b_reg[k]) begin
                s = SW'(k + 1);
            end else begin
                run = 1'b0;
            end
        end
        last = ((b_reg >> s) == '0);
    end

endmodule

`default_nettype wire

// File: rtl/imul_int_mul_var_lat.sv
// ============================================================================
// imul_int_mul_var_lat : variable-latency zero-skipping iterative multiplier
//                        with signed/unsigned operands and hi/lo half select
// Rev 1.0
// ============================================================================
`default_nettype none

module imul_int_mul_var_lat
    import imul_pkg::*;
#(
    parameter int NBITS    = 32,
    parameter int MAX_SKIP = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_val,
    output logic                 req_rdy,
    input  logic [2*NBITS+1:0]   req_msg,
    output logic                 resp_val,
    input  logic                 resp_rdy,
    output logic [NBITS-1:0]     resp_msg
);

    localparam int SW      = $clog2(MAX_SKIP + 1);
    localparam int SGN_POS = sgn_pos(NBITS);
    localparam int HI_POS  = hi_pos(NBITS);

    state_t             state_q, state_d;
    logic [2*NBITS-1:0] a_reg_q, a_reg_d;
    logic [2*NBITS-1:0] prod_q, prod_d;
    logic [NBITS-1:0]   b_reg_q, b_reg_d;
    logic               neg_q, neg_d;
    logic               hi_r_q, hi_r_d;

    logic [NBITS-1:0]   op_a, op_b, mag_a, mag_b;
    logic               op_sgn, op_hi;
    logic [2*NBITS-1:0] prod_p;
    logic [SW-1:0]      skip_s;
    logic               skip_last;

    assign op_sgn = req_msg[SGN_POS];
    assign op_hi  = req_msg[HI_POS];
    assign op_a   = req_msg[2*NBITS-1:NBITS];
    assign op_b   = req_msg[NBITS-1:0];

    // Unsigned magnitudes; -2^(N-1) maps to 2^(N-1), which still fits in N bits.
    assign mag_a  = (op_sgn && op_a[NBITS-1]) ? (~op_a + NBITS'(1)) : op_a;
    assign mag_b  = (op_sgn && op_b[NBITS-1]) ? (~op_b + NBITS'(1)) : op_b;

    assign prod_p = neg_q ? (~prod_q + (2*NBITS)'(1)) : prod_q;

    imul_zero_skip #(
        .NBITS    (NBITS),
        .MAX_SKIP (MAX_SKIP)
    ) u_zero_skip (
        .b_reg (b_reg_q),
        .s     (skip_s),
        .last  (skip_last)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            a_reg_q <= '0;
            b_reg_q <= '0;
            prod_q  <= '0;
            neg_q   <= 1'b0;
            hi_r_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_reg_q <= a_reg_d;
            b_reg_q <= b_reg_d;
            prod_q  <= prod_d;
            neg_q   <= neg_d;
            hi_r_q  <= hi_r_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_reg_d  = a_reg_q;
        b_reg_d  = b_reg_q;
        prod_d   = prod_q;
        neg_d    = neg_q;
        hi_r_d   = hi_r_q;
        req_rdy  = 1'b0;
        resp_val = 1'b0;
        resp_msg = '0;

        case (state_q)
            IDLE: begin
                // Gated by reset so no request is accepted in a reset cycle.
                req_rdy = reset;
                if (req_val && reset) begin
                    a_reg_d = {{NBITS{1'b0}}, mag_a};
                    b_reg_d = mag_b;
                    prod_d  = '0;
                    neg_d   = op_sgn & (op_a[NBITS-1] ^ op_b[NBITS-1]);
                    hi_r_d  = op_hi;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (b_reg_q[0]) begin
                    prod_d = prod_q + a_reg_q;
                end
                a_reg_d = a_reg_q << skip_s;
                b_reg_d = b_reg_q >> skip_s;
                if (skip_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                resp_val = 1'b1;
                resp_msg = hi_r_q ? prod_p[2*NBITS-1:NBITS] : prod_p[NBITS-1:0];
                if (resp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_imul_int_mul_var_lat.sv
// ============================================================================
// tb_imul_int_mul_var_lat : scoreboard bench for the variable-latency multiplier
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_imul_int_mul_var_lat;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_val, req_rdy;
    logic [65:0] req_msg;
    logic        resp_val, resp_rdy;
    logic [31:0] resp_msg;

    logic        req_val16, req_rdy16;
    logic [33:0] req_msg16;
    logic        resp_val16, resp_rdy16;
    logic [15:0] resp_msg16;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    imul_int_mul_var_lat #(.NBITS(32), .MAX_SKIP(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_msg  (req_msg),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .resp_msg (resp_msg)
    );

    imul_int_mul_var_lat #(.NBITS(16), .MAX_SKIP(4)) dut16 (
        .clk      (clk),
        .reset    (reset),
        .req_val  (req_val16),
        .req_rdy  (req_rdy16),
        .req_msg  (req_msg16),
        .resp_val (resp_val16),
        .resp_rdy (resp_rdy16),
        .resp_msg (resp_msg16)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Reference product from sign-extended 64-bit operands.
    function automatic logic [31:0] model(input bit sgn, input bit hi,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {{32{sgn & a[31]}}, a} * {{32{sgn & b[31]}}, b};
        return hi ? p[63:32] : p[31:0];
    endfunction

    task automatic txn(input string tag, input bit sgn, input bit hi,
                       input logic [31:0] a, input logic [31:0] b,
                       input int exp_lat, input int hold);
        int          w;
        int          lat;
        logic [31:0] held;
        logic [31:0] e;
        w = 0;
        while (!req_rdy && w < 50) begin
            @(negedge clk);
            w++;
        end
        check_eq({tag, " req_rdy"}, 64'(req_rdy), 64'd1);
        req_val = 1'b1;
        req_msg = {sgn, hi, a, b};
        exp_q.push_back(model(sgn, hi, a, b));
        @(negedge clk);
        req_val = 1'b0;
        lat = 1;
        while (!resp_val && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, " resp_val"}, 64'(resp_val), 64'd1);
        if (exp_lat > 0) begin
            check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
        end
        held = resp_msg;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq({tag, " hold msg"}, 64'(resp_msg), 64'(held));
            check_eq({tag, " hold val"}, 64'(resp_val), 64'd1);
            check_eq({tag, " hold rdy"}, 64'(req_rdy), 64'd0);
        end
        e = exp_q.pop_front();
        check_eq({tag, " msg"}, 64'(resp_msg), 64'(e));
        check_eq({tag, " done rdy"}, 64'(req_rdy), 64'd0);
        resp_rdy = 1'b1;
        @(negedge clk);
        resp_rdy = 1'b0;
        check_eq({tag, " after rdy"}, 64'(req_rdy), 64'd1);
        check_eq({tag, " after val"}, 64'(resp_val), 64'd0);
    endtask

    initial begin
        int          lat;
        int          seen;
        logic [31:0] ra, rb;
        bit          rs, rh;

        reset      = 1'b0;
        req_val    = 1'b0;
        req_msg    = '0;
        resp_rdy   = 1'b0;
        req_val16  = 1'b0;
        req_msg16  = '0;
        resp_rdy16 = 1'b1;

        repeat (2) @(negedge clk);
        check_eq("reset req_rdy", 64'(req_rdy), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("post reset req_rdy", 64'(req_rdy), 64'd1);
        check_eq("post reset resp_val", 64'(resp_val), 64'd0);
        check_eq("post reset resp_msg", 64'(resp_msg), 64'd0);

        txn("u3x4",     1'b0, 1'b0, 32'd3,          32'd4,          3,  0);
        check_eq("u3x4 const", 64'(model(1'b0, 1'b0, 32'd3, 32'd4)), 64'h0000000C);
        txn("s_lo",     1'b1, 1'b0, 32'hFFFFFFFD,   32'd5,          0,  0);
        txn("s_hi",     1'b1, 1'b1, 32'hFFFFFFFD,   32'd5,          0,  0);
        txn("u_hi",     1'b0, 1'b1, 32'h80000000,   32'h80000000,   10, 0);
        txn("u_lo",     1'b0, 1'b0, 32'h80000000,   32'h80000000,   10, 0);
        txn("s_ext_bp", 1'b1, 1'b1, 32'h80000000,   32'h80000000,   0,  5);
        txn("zero_s",   1'b1, 1'b0, 32'h12345678,   32'd0,          2,  0);
        txn("zero_hi",  1'b1, 1'b1, 32'hF2345678,   32'd0,          2,  0);
        txn("s_negneg", 1'b1, 1'b1, 32'hFFFF0001,   32'h80000001,   0,  2);

        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            rs = 1'($urandom_range(0, 1));
            rh = 1'($urandom_range(0, 1));
            txn("rand", rs, rh, ra, rb, 0, 0);
        end

        // Abort a long transaction with a reset mid-CALC.
        req_val = 1'b1;
        req_msg = {2'b00, 32'h00001234, 32'hFFFFFFFF};
        @(negedge clk);
        req_val = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("abort calc val", 64'(resp_val), 64'd0);
        reset = 1'b0;
        #1;
        check_eq("abort rst rdy", 64'(req_rdy), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("abort after rdy", 64'(req_rdy), 64'd1);
        check_eq("abort after val", 64'(resp_val), 64'd0);
        check_eq("abort after msg", 64'(resp_msg), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_val) seen++;
        end
        check_eq("abort no resp", 64'(seen), 64'd0);

        txn("post_abort", 1'b0, 1'b0, 32'd7, 32'd9, 0, 0);

        // Narrow instance: 0xFFFF * 0xFFFF = 0xFFFE0001.
        for (int k = 0; k < 2; k++) begin
            check_eq("n16 req_rdy", 64'(req_rdy16), 64'd1);
            req_val16 = 1'b1;
            req_msg16 = {1'b0, (k == 0), 16'hFFFF, 16'hFFFF};
            @(negedge clk);
            req_val16 = 1'b0;
            lat = 1;
            while (!resp_val16 && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            check_eq("n16 resp_val", 64'(resp_val16), 64'd1);
            check_eq("n16 msg", 64'(resp_msg16), (k == 0) ? 64'hFFFE : 64'h0001);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
